fb_write_arbiter: RTL and testbench

- Shares the single write port of one colour-plane frame buffer (640x480, 8-bit pixels, ports write_enable/data_in/data_in_x/data_in_y) between two requesters and an internal clear sequencer.
- Requester A is the capture path (camera pixel stream); requester B is the draw/processing engine.
- The clear sequencer sweeps the whole raster with a constant value on command.
- The buffer read port is not touched by this block.

---
 rtl/fb_write_arbiter_if.sv | 45 ++++
 rtl/fb_write_arbiter.sv | 130 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// Bus bundle for fb_write_arbiter: two pixel requesters, clear control and the
// frame-buffer write port. master = requester/buffer side, slave = arbiter.
interface fb_write_arbiter_if #(
    parameter int COORD_W = 11,
    parameter int DATA_W  = 8
);
    logic               a_valid;
    logic               a_ready;
    logic [COORD_W-1:0] a_x;
    logic [COORD_W-1:0] a_y;
    logic [DATA_W-1:0]  a_data;

    logic               b_valid;
    logic               b_ready;
    logic [COORD_W-1:0] b_x;
    logic [COORD_W-1:0] b_y;
    logic [DATA_W-1:0]  b_data;

    logic               clear_start;
    logic [DATA_W-1:0]  clear_value;
    logic               clear_busy;
    logic               clear_done;

    logic               fb_write_enable;
    logic [DATA_W-1:0]  fb_data_in;
    logic [COORD_W-1:0] fb_data_in_x;
    logic [COORD_W-1:0] fb_data_in_y;
    logic [15:0]        drop_count;

    modport master (
        output a_valid, a_x, a_y, a_data,
        output b_valid, b_x, b_y, b_data,
        output clear_start, clear_value,
        input  a_ready, b_ready, clear_busy, clear_done,
        input  fb_write_enable, fb_data_in, fb_data_in_x, fb_data_in_y, drop_count
    );

    modport slave (
        input  a_valid, a_x, a_y, a_data,
        input  b_valid, b_x, b_y, b_data,
        input  clear_start, clear_value,
        output a_ready, b_ready, clear_busy, clear_done,
        output fb_write_enable, fb_data_in, fb_data_in_x, fb_data_in_y, drop_count
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: A (capture) over B (draw) plus a full-raster clear sweep.
// Optional macro FB_ARB_STARVE_GUARD_EN forces a B grant after STARVE_LIMIT consecutive A wins.
module fb_write_arbiter #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int COORD_W      = 11,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    fb_write_arbiter_if.slave bus
);
    typedef enum logic [0:0] {ARB, CLEAR} state_t;

    state_t             state_reg;
    logic [COORD_W-1:0] clr_x_reg;
    logic [COORD_W-1:0] clr_y_reg;
    logic [DATA_W-1:0]  clr_val_reg;
    logic               fb_we_reg;
    logic [DATA_W-1:0]  fb_data_reg;
    logic [COORD_W-1:0] fb_x_reg;
    logic [COORD_W-1:0] fb_y_reg;
    logic               clear_done_reg;
    logic [15:0]        drop_count_reg;

    logic               in_arb;
    logic               starve_force;
    logic               a_fire;
    logic               b_fire;
    logic [COORD_W-1:0] sel_x;
    logic [COORD_W-1:0] sel_y;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_in_range;

    // Readies stay low while reset is held so nothing is handshaken during reset.
    assign in_arb   = (state_reg == ARB) && !reset;
    assign a_fire   = bus.a_valid && bus.a_ready;
    assign b_fire   = bus.b_valid && bus.b_ready;
    assign sel_x    = a_fire ? bus.a_x    : bus.b_x;
    assign sel_y    = a_fire ? bus.a_y    : bus.b_y;
    assign sel_data = a_fire ? bus.a_data : bus.b_data;
    assign sel_in_range = (sel_x < COORD_W'(H_RES)) && (sel_y < COORD_W'(V_RES));

    assign bus.a_ready = in_arb && !bus.clear_start && !starve_force;
    assign bus.b_ready = in_arb && !bus.clear_start && (!bus.a_valid || starve_force);

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_reg;

    assign starve_force = (starve_cnt_reg == CNT_W'(STARVE_LIMIT)) && bus.a_valid && bus.b_valid;

    // Counts only contended cycles that A wins; any other ARB cycle restarts the streak.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if (state_reg == ARB && !bus.clear_start && bus.a_valid && bus.b_valid) begin
            starve_cnt_reg <= starve_force ? '0 : starve_cnt_reg + 1'b1;
        end else begin
            starve_cnt_reg <= '0;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg      <= ARB;
            clr_x_reg      <= '0;
            clr_y_reg      <= '0;
            clr_val_reg    <= '0;
            fb_we_reg      <= 1'b0;
            fb_data_reg    <= '0;
            fb_x_reg       <= '0;
            fb_y_reg       <= '0;
            clear_done_reg <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            fb_we_reg      <= 1'b0;
            clear_done_reg <= 1'b0;
            case (state_reg)
                ARB: begin
                    if (bus.clear_start) begin
                        clr_val_reg <= bus.clear_value;
                        clr_x_reg   <= '0;
                        clr_y_reg   <= '0;
                        state_reg   <= CLEAR;
                    end else if (a_fire || b_fire) begin
                        if (sel_in_range) begin
                            fb_we_reg   <= 1'b1;
                            fb_data_reg <= sel_data;
                            fb_x_reg    <= sel_x;
                            fb_y_reg    <= sel_y;
                        end else if (drop_count_reg != 16'hFFFF) begin
                            drop_count_reg <= drop_count_reg + 16'd1;
                        end
                    end
                end
                CLEAR: begin
                    fb_we_reg   <= 1'b1;
                    fb_data_reg <= clr_val_reg;
                    fb_x_reg    <= clr_x_reg;
                    fb_y_reg    <= clr_y_reg;
                    if (clr_x_reg == COORD_W'(H_RES - 1)) begin
                        clr_x_reg <= '0;
                        if (clr_y_reg == COORD_W'(V_RES - 1)) begin
                            state_reg      <= ARB;
                            clear_done_reg <= 1'b1;
                        end else begin
                            clr_y_reg <= clr_y_reg + 1'b1;
                        end
                    end else begin
                        clr_x_reg <= clr_x_reg + 1'b1;
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    assign bus.fb_write_enable = fb_we_reg;
    assign bus.fb_data_in      = fb_data_reg;
    assign bus.fb_data_in_x    = fb_x_reg;
    assign bus.fb_data_in_y    = fb_y_reg;
    assign bus.clear_busy      = (state_reg == CLEAR);
    assign bus.clear_done      = clear_done_reg;
    assign bus.drop_count      = drop_count_reg;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter on a reduced 40x30 raster; the stimulus side
// predicts grants and writes from the arbitration rules, a monitor pops and compares writes.
module tb_fb_write_arbiter;
    localparam int H   = 40;
    localparam int V   = 30;
    localparam int CW  = 11;
    localparam int DW  = 8;
    localparam int LIM = 16;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fb_write_arbiter_if #(.COORD_W(CW), .DATA_W(DW)) bus();

    fb_write_arbiter #(
        .H_RES(H), .V_RES(V), .COORD_W(CW), .DATA_W(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  m_clear_left = 0;
    bit  m_done = 0;
    int  m_drop = 0;
    int  m_streak = 0;
    bit  a_acc = 0;
    bit  b_acc = 0;
    bit  verbose = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void accept(string who, logic [CW-1:0] x, logic [CW-1:0] y, logic [DW-1:0] d);
        if (int'(x) < H && int'(y) < V) begin
            exp_q.push_back('{x: x, y: y, d: d});
            if (verbose) $display("xfer %s x=%0d y=%0d data=%02h -> write", who, x, y, d);
        end else begin
            if (m_drop < 65535) m_drop++;
            if (verbose) $display("xfer %s x=%0d y=%0d data=%02h -> dropped", who, x, y, d);
        end
    endfunction

    // One clock of the reference model: inputs are already driven at posedge+1.
    task automatic step();
        bit clearing, er_a, er_b, cs, av, bv;
        #1;
        cs = bus.clear_start;
        av = bus.a_valid;
        bv = bus.b_valid;
        clearing = (m_clear_left > 0);
        if (clearing) begin
            er_a = 0;
            er_b = 0;
        end else begin
            er_a = !cs;
            er_b = !cs && !av;
`ifdef FB_ARB_STARVE_GUARD_EN
            if (!cs && av && bv && m_streak == LIM) begin
                er_a = 0;
                er_b = 1;
            end
`endif
        end
        chk("a_ready", bus.a_ready, er_a);
        chk("b_ready", bus.b_ready, er_b);
        chk("clear_busy", bus.clear_busy, clearing);
        chk("clear_done", bus.clear_done, m_done);
        chk("drop_count", bus.drop_count, m_drop);
        a_acc = av && er_a;
        b_acc = bv && er_b;
        m_done = 0;
        if (clearing) begin
            m_clear_left--;
            if (m_clear_left == 0) m_done = 1;
            m_streak = 0;
        end else if (cs) begin
            for (int yy = 0; yy < V; yy++)
                for (int xx = 0; xx < H; xx++)
                    exp_q.push_back('{x: CW'(xx), y: CW'(yy), d: bus.clear_value});
            m_clear_left = H * V;
            m_streak = 0;
            if (verbose) $display("clear start value=%02h", bus.clear_value);
        end else begin
            if (av && bv) m_streak = er_b ? 0 : m_streak + 1;
            else m_streak = 0;
            if (a_acc) accept("A", bus.a_x, bus.a_y, bus.a_data);
            else if (b_acc) accept("B", bus.b_x, bus.b_y, bus.b_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 0; bus.b_valid = 0; bus.clear_start = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        bus.a_valid = 1; bus.a_x = 1; bus.a_y = 1; bus.a_data = 8'h11;
        bus.b_valid = 0; bus.clear_start = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("reset_a_ready", bus.a_ready, 0);
            chk("reset_b_ready", bus.b_ready, 0);
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        reset = 0;
        idle_inputs();
        m_clear_left = 0; m_done = 0; m_drop = 0; m_streak = 0;
        chk("reset_we", bus.fb_write_enable, 0);
        chk("reset_drop", bus.drop_count, 0);
        chk("reset_busy", bus.clear_busy, 0);
        chk("reset_done", bus.clear_done, 0);
    endtask

    function automatic logic [CW-1:0] rnd_coord(int lim);
        if ($urandom_range(0, 99) < 90) return CW'($urandom_range(0, lim - 1));
        return CW'($urandom_range(lim, 2047));
    endfunction

    task automatic rand_phase(int n, int p_clear);
        for (int i = 0; i < n; i++) begin
            if (!bus.a_valid || a_acc) begin
                bus.a_valid = ($urandom_range(0, 99) < 60);
                bus.a_x = rnd_coord(H); bus.a_y = rnd_coord(V); bus.a_data = DW'($urandom);
            end
            if (!bus.b_valid || b_acc) begin
                bus.b_valid = ($urandom_range(0, 99) < 60);
                bus.b_x = rnd_coord(H); bus.b_y = rnd_coord(V); bus.b_data = DW'($urandom);
            end
            bus.clear_start = ($urandom_range(0, 999) < p_clear);
            bus.clear_value = DW'($urandom);
            step();
        end
    endtask

    // Monitor: every presented write must match the head of the scoreboard; idle cycles hold.
    initial begin
        wr_t e;
        logic [CW-1:0] lx = '0;
        logic [CW-1:0] ly = '0;
        logic [DW-1:0] ld = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (bus.fb_write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write actual x=%0d y=%0d data=%02h required=no write",
                             bus.fb_data_in_x, bus.fb_data_in_y, bus.fb_data_in);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_x", bus.fb_data_in_x, e.x);
                    chk("write_y", bus.fb_data_in_y, e.y);
                    chk("write_data", bus.fb_data_in, e.d);
                    lx = e.x; ly = e.y; ld = e.d;
                end
            end else begin
                chk("idle_we", bus.fb_write_enable, 0);
                chk("hold_x", bus.fb_data_in_x, lx);
                chk("hold_y", bus.fb_data_in_y, ly);
                chk("hold_data", bus.fb_data_in, ld);
            end
            if (reset) begin
                lx = '0; ly = '0; ld = '0;
            end
        end
    end

    initial begin
        idle_inputs();
        bus.a_x = 0; bus.a_y = 0; bus.a_data = 0;
        bus.b_x = 0; bus.b_y = 0; bus.b_data = 0; bus.clear_value = 0;
        do_reset();
        verbose = 1;

        // First transfer after reset.
        bus.a_valid = 1; bus.a_x = 5; bus.a_y = 7; bus.a_data = 8'h3C;
        step();
        idle_inputs();
        step();

        // Contention: A wins three times, then B goes through once A drops.
        bus.b_valid = 1; bus.b_x = 9; bus.b_y = 9; bus.b_data = 8'hB0;
        for (int i = 0; i < 3; i++) begin
            bus.a_valid = 1; bus.a_x = CW'(10 + i); bus.a_y = 2; bus.a_data = DW'(8'hA0 + i);
            step();
        end
        bus.a_valid = 0;
        step();
        idle_inputs();
        step();

        // Out-of-range writes are accepted but dropped.
        bus.a_valid = 1;
        bus.a_x = CW'(H); bus.a_y = 0; bus.a_data = 8'h01; step();
        bus.a_x = 0; bus.a_y = CW'(V); bus.a_data = 8'h02; step();
        bus.a_x = 11'd2047; bus.a_y = 11'd2047; bus.a_data = 8'h03; step();
        idle_inputs();
        step();
        chk("drop_three", bus.drop_count, 3);

        // Full sweep with a second clear_start mid-sweep and A pending throughout.
        bus.clear_start = 1; bus.clear_value = 8'h00;
        step();
        bus.clear_start = 0;
        bus.a_valid = 1; bus.a_x = 3; bus.a_y = 4; bus.a_data = 8'h5A;
        verbose = 0;
        for (int i = 0; i < H * V + 2; i++) begin
            bus.clear_start = (i == 500);
            step();
            if (a_acc) bus.a_valid = 0;
        end
        idle_inputs();
        step();
        verbose = 1;

        // Abort a sweep with reset at write 1000: no clear_done afterwards.
        bus.clear_start = 1; bus.clear_value = 8'hE7;
        step();
        bus.clear_start = 0;
        verbose = 0;
        for (int i = 0; i < 1000; i++) step();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        verbose = 1;

        // Both requesters held high: strict priority, or 16 A then 1 B with the guard.
        bus.a_valid = 1; bus.b_valid = 1;
        for (int i = 0; i < 40; i++) begin
            if (a_acc) begin bus.a_x = CW'(i % H); bus.a_y = 1; bus.a_data = DW'(i); end
            if (b_acc || i == 0) begin bus.b_x = CW'(i % H); bus.b_y = 2; bus.b_data = DW'(8'h80 + i); end
            step();
        end
        idle_inputs();
        step();
        verbose = 0;

        rand_phase(3000, 2);
        idle_inputs();
        for (int i = 0; i < H * V + 2; i++) step();

        // Saturate the drop counter.
        bus.a_valid = 1; bus.a_x = 11'd2047; bus.a_y = 0;
        for (int i = 0; i < 65540; i++) step();
        idle_inputs();
        step();
        chk("drop_saturated", bus.drop_count, 16'hFFFF);

        step();
        step();
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
